// File: rtl/fetch_sequencer.sv
// Fetch/issue sequencer: fetches one instruction, decodes, and holds it for the controller.
// Optional macro FETCH_TIMEOUT_EN adds a fetch timeout that halts with fetch_err.
module fetch_sequencer #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] pc,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             pcEn,
    output logic             go_contr,
    output logic [6:0]       opcode,
    output logic [2:0]       func3,
    output logic [6:0]       func7,
    output logic [WIDTH-1:0] instr,
    output logic             busy,
    output logic             illegal,
    output logic             fetch_err,
    output logic [15:0]      retired_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

    state_t           r_state;
    logic             r_imem_req;
    logic             r_go_contr;
    logic             r_busy;
    logic             r_illegal;
    logic [WIDTH-1:0] r_instr;
    logic [15:0]      r_retired_count;
    logic             w_legal;

`ifdef FETCH_TIMEOUT_EN
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] r_tcnt;
    logic          r_fetch_err;
`endif

    always_comb begin
        w_legal = 1'b0;
        case (r_instr[6:0])
            7'b0110011, 7'b0010011, 7'b0000011,
            7'b0100011, 7'b1100011, 7'b1101111,
            7'b1100111, 7'b0110111, 7'b0010111: w_legal = 1'b1;
            default:                            w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_imem_req      <= 1'b0;
            r_go_contr      <= 1'b0;
            r_busy          <= 1'b0;
            r_illegal       <= 1'b0;
            r_instr         <= '0;
            r_retired_count <= '0;
`ifdef FETCH_TIMEOUT_EN
            r_tcnt          <= '0;
            r_fetch_err     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_FETCH;
                        r_imem_req <= 1'b1;
                        r_busy     <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                        r_tcnt     <= '0;
`endif
                    end
                end
                S_FETCH: begin
                    // An ack in the expiry cycle still wins over the timeout
                    if (imem_ack) begin
                        r_instr    <= imem_rdata;
                        r_imem_req <= 1'b0;
                        r_state    <= S_DECODE;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (r_tcnt == TCNT_LAST) begin
                        r_fetch_err <= 1'b1;
                        r_imem_req  <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_HALT;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
`endif
                end
                S_DECODE: begin
                    if (w_legal) begin
                        r_state    <= S_EXEC;
                        r_go_contr <= 1'b1;
                    end else begin
                        r_illegal <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_HALT;
                    end
                end
                S_EXEC: begin
                    if (pcEn) begin
                        r_go_contr      <= 1'b0;
                        r_retired_count <= r_retired_count + 16'd1;
                        if (stop) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state    <= S_FETCH;
                            r_imem_req <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                            r_tcnt     <= '0;
`endif
                        end
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_imem_req <= 1'b0;
                    r_go_contr <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req      = r_imem_req;
    assign imem_addr     = pc;
    assign go_contr      = r_go_contr;
    assign instr         = r_instr;
    assign opcode        = r_instr[6:0];
    assign func3         = r_instr[14:12];
    assign func7         = r_instr[31:25];
    assign busy          = r_busy;
    assign illegal       = r_illegal;
    assign retired_count = r_retired_count;

`ifdef FETCH_TIMEOUT_EN
    assign fetch_err = r_fetch_err;
`else
    assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed instruction stream,
// decoded fields and go_contr pulse lengths checked by a separate monitor.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic [31:0] pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        pcEn;
    logic        go_contr;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] instr;
    logic        busy;
    logic        illegal;
    logic        fetch_err;
    logic [15:0] retired_count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        int         len;
    } exp_t;

    exp_t q[$];

    fetch_sequencer #(.WIDTH(32), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .pc(pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .pcEn(pcEn), .go_contr(go_contr),
        .opcode(opcode), .func3(func3), .func7(func7), .instr(instr),
        .busy(busy), .illegal(illegal), .fetch_err(fetch_err),
        .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per go_contr pulse
    logic prev_go = 1'b0;
    int   run_len = 0;
    exp_t cur;
    always @(negedge clk) begin
        if (go_contr && !prev_go) begin
            run_len = 1;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_go: got pulse expected none");
                cur = '{7'd0, 3'd0, 7'd0, -1};
            end else begin
                cur = q.pop_front();
                chk("opcode", {25'd0, opcode}, {25'd0, cur.op});
                chk("func3", {29'd0, func3}, {29'd0, cur.f3});
                chk("func7", {25'd0, func7}, {25'd0, cur.f7});
            end
        end else if (go_contr) begin
            run_len++;
        end
        if (!go_contr && prev_go && cur.len >= 0)
            chk("go_len", run_len, cur.len);
        prev_go = go_contr;
    end

    task automatic chk_reset_vals();
        chk("rst_instr", instr, 32'h0);
        chk("rst_count", {16'd0, retired_count}, 32'h0);
        chk("rst_illegal", {31'd0, illegal}, 32'h0);
        chk("rst_fetch_err", {31'd0, fetch_err}, 32'h0);
        chk("rst_req", {31'd0, imem_req}, 32'h0);
        chk("rst_go", {31'd0, go_contr}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        chk("rst_addr", imem_addr, pc);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_reset_vals();
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic kick(input logic stp);
        start = 1'b1;
        stop  = stp;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    // Ends on the DECODE-cycle negedge
    task automatic fetch(input logic [31:0] w, input int adly);
        int n;
        n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!imem_req) begin
            checks++;
            errors++;
            $display("FAIL req_wait: got no imem_req expected imem_req");
            return;
        end
        repeat (adly) begin
            @(negedge clk);
            chk("req_hold", {31'd0, imem_req}, 32'h1);
        end
        chk("imem_addr", imem_addr, pc);
        imem_ack   = 1'b1;
        imem_rdata = w;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = '0;
    endtask

    task automatic run_instr(input logic [31:0] w, input int adly,
                             input int elen, input logic stp);
        q.push_back('{w[6:0], w[14:12], w[31:25], elen});
        fetch(w, adly);
        @(negedge clk);
        repeat (elen - 1) @(negedge clk);
        pcEn = 1'b1;
        stop = stp;
        @(negedge clk);
        pcEn = 1'b0;
        stop = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        stop       = 1'b0;
        pc         = 32'h0000_0100;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        pcEn       = 1'b0;
        @(negedge clk);
        do_reset();

        // add, ack one cycle after req, three EXEC cycles
        kick(1'b0);
        run_instr(32'h0000_0033, 1, 3, 1'b0);
        chk("count_1", {16'd0, retired_count}, 32'd1);
        chk("b2b_req", {31'd0, imem_req}, 32'h1);

        // sra, back-to-back, single EXEC cycle
        pc = 32'h0000_0104;
        run_instr(32'h4020_D0B3, 0, 1, 1'b0);
        chk("count_2", {16'd0, retired_count}, 32'd2);

        // lui with stop on the retire cycle
        pc = 32'h0000_0108;
        run_instr(32'h1234_5037, 0, 2, 1'b1);
        chk("stop_busy", {31'd0, busy}, 32'h0);
        chk("stop_req", {31'd0, imem_req}, 32'h0);
        chk("count_3", {16'd0, retired_count}, 32'd3);
        repeat (3) @(negedge clk);
        chk("idle_req", {31'd0, imem_req}, 32'h0);

        // start and stop together in IDLE, then an illegal opcode
        kick(1'b1);
        chk("ss_req", {31'd0, imem_req}, 32'h1);
        chk("ss_busy", {31'd0, busy}, 32'h1);
        fetch(32'hFFFF_FFFF, 0);
        @(negedge clk);
        chk("ill_flag", {31'd0, illegal}, 32'h1);
        chk("ill_busy", {31'd0, busy}, 32'h0);
        chk("ill_go", {31'd0, go_contr}, 32'h0);
        kick(1'b0);
        repeat (3) @(negedge clk);
        chk("halt_req", {31'd0, imem_req}, 32'h0);
        chk("halt_busy", {31'd0, busy}, 32'h0);
        chk("halt_ill", {31'd0, illegal}, 32'h1);
        chk("halt_count", {16'd0, retired_count}, 32'd3);
        do_reset();

        // ack and pcEn in IDLE are ignored
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0033;
        pcEn       = 1'b1;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = '0;
        pcEn       = 1'b0;
        @(negedge clk);
        chk("ign_instr", instr, 32'h0);
        chk("ign_count", {16'd0, retired_count}, 32'd0);
        chk("ign_busy", {31'd0, busy}, 32'h0);

        // reset in the middle of EXEC
        kick(1'b0);
        q.push_back('{7'b1100011, 3'd0, 7'd0, 2});
        fetch(32'h0000_0063, 0);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        #1 chk("rst_go_now", {31'd0, go_contr}, 32'h0);
        chk("rst_req_now", {31'd0, imem_req}, 32'h0);
        @(negedge clk);
        chk_reset_vals();
        reset = 1'b0;
        @(negedge clk);

        // counter wrap, preloaded to 0xFFFE
        force dut.r_retired_count = 16'hFFFE;
        @(negedge clk);
        release dut.r_retired_count;
        @(negedge clk);
        chk("preload", {16'd0, retired_count}, 32'h0000_FFFE);
        kick(1'b0);
        run_instr(32'h0000_006F, 0, 1, 1'b0);
        chk("count_ffff", {16'd0, retired_count}, 32'h0000_FFFF);
        run_instr(32'h0000_0067, 0, 1, 1'b1);
        chk("count_wrap", {16'd0, retired_count}, 32'h0000_0000);
        do_reset();

        // ack withheld in FETCH
        kick(1'b0);
`ifdef FETCH_TIMEOUT_EN
        repeat (14) @(negedge clk);
        chk("to_pre_err", {31'd0, fetch_err}, 32'h0);
        chk("to_pre_req", {31'd0, imem_req}, 32'h1);
        @(negedge clk);
        chk("to_err", {31'd0, fetch_err}, 32'h1);
        chk("to_req", {31'd0, imem_req}, 32'h0);
        chk("to_busy", {31'd0, busy}, 32'h0);
`else
        repeat (40) @(negedge clk);
        chk("noto_req", {31'd0, imem_req}, 32'h1);
        chk("noto_err", {31'd0, fetch_err}, 32'h0);
        chk("noto_busy", {31'd0, busy}, 32'h1);
`endif
        do_reset();

        chk("queue_empty", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
